// File: rtl/gpio_bank.sv
// -----------------------------------------------------------------------------
// gpio_bank
// Parametrised GPIO bank behind a single-cycle register decoder. It holds the
// per-pin output data and direction registers, a two-flop input synchroniser,
// per-bit edge detection, and a maskable sticky interrupt.
//
// Parameters
//   WIDTH    number of pins and register data width (1..32)
//   RST_DIR  reset value of every DIR bit (1 = output)
//
// Ports
//   clock    in   system clock, rising edge
//   reset    in   asynchronous, active-high, clears all state
//   en       in   access strobe, one cycle per access
//   we       in   1 = write, 0 = read (qualified by en)
//   addr     in   register index
//   wdata    in   write data
//   rdata    out  read data, valid with rvalid, holds until the next read
//   rvalid   out  one-cycle pulse in the cycle after a read strobe
//   pin_in   in   asynchronous pad inputs
//   pin_out  out  DATA_OUT register
//   pin_dir  out  DIR register (1 = drive)
//   irq      out  registered OR of (IRQ_STATUS & IRQ_EN)
//
// Register map
//   0 DATA_OUT rw | 1 DIR rw | 2 DATA_IN ro | 3 IRQ_EN rw | 4 IRQ_STATUS w1c
//   5 EDGE_SEL rw (1 rising, 0 falling) | 6 OUT_SET wo | 7 OUT_CLR wo
//
// Build option
//   GPIO_SETCLR_EN  when defined, writes to 6/7 set/clear DATA_OUT bits. When
//                   undefined, those writes are ignored. Both addresses always
//                   read 0.
// -----------------------------------------------------------------------------
module gpio_bank #(
    parameter int WIDTH   = 8,
    parameter bit RST_DIR = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_dir,
    output logic             irq
);

    typedef enum logic [2:0] {
        REG_DATA_OUT   = 3'd0,
        REG_DIR        = 3'd1,
        REG_DATA_IN    = 3'd2,
        REG_IRQ_EN     = 3'd3,
        REG_IRQ_STATUS = 3'd4,
        REG_EDGE_SEL   = 3'd5,
        REG_OUT_SET    = 3'd6,
        REG_OUT_CLR    = 3'd7
    } reg_addr_e;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] irq_status;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] s1, s2, s3;

    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] w1c_mask;
    logic [WIDTH-1:0] rdata_next;

    assign wr = en & we;
    assign rd = en & ~we;

    // s2 is the synchronised DATA_IN and s3 is its previous sample. The
    // detection reads the registered EDGE_SEL. A change of polarity therefore
    // applies to the next comparison and never creates an edge of its own.
    assign edge_det = (edge_sel & s2 & ~s3) | (~edge_sel & ~s2 & s3);
    assign w1c_mask = (wr && addr == REG_IRQ_STATUS) ? wdata : '0;

    assign pin_out = data_out;
    assign pin_dir = dir;

    // NOTE: every combinational output gets a default first. A path that
    // leaves it unassigned would infer a latch.
    always_comb begin
        rdata_next = '0;
        case (addr)
            REG_DATA_OUT:   rdata_next = data_out;
            REG_DIR:        rdata_next = dir;
            REG_DATA_IN:    rdata_next = s2;
            REG_IRQ_EN:     rdata_next = irq_en;
            REG_IRQ_STATUS: rdata_next = irq_status;
            REG_EDGE_SEL:   rdata_next = edge_sel;
            default:        rdata_next = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples the values from before the edge, so the order of the
    // statements has no effect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out <= '0;
            dir      <= {WIDTH{RST_DIR}};
            irq_en   <= '0;
            edge_sel <= '0;
        end else if (wr) begin
            case (addr)
                REG_DATA_OUT: data_out <= wdata;
                REG_DIR:      dir      <= wdata;
                REG_IRQ_EN:   irq_en   <= wdata;
                REG_EDGE_SEL: edge_sel <= wdata;
`ifdef GPIO_SETCLR_EN
                REG_OUT_SET:  data_out <= data_out | wdata;
                REG_OUT_CLR:  data_out <= data_out & ~wdata;
`endif
                default: ;
            endcase
        end
    end

    // The input path is pad -> s1 -> s2 (DATA_IN) -> s3 (previous sample).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= pin_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // The sticky status is applied after the W1C clear. A new edge in the same
    // cycle as a clear keeps its bit set. IRQ_EN does not gate the status.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            irq_status <= (irq_status & ~w1c_mask) | edge_det;
            irq        <= |(irq_status & irq_en);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd;
            if (rd) rdata <= rdata_next;
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
// -----------------------------------------------------------------------------
// tb_gpio_bank
// Directed bench for gpio_bank with WIDTH=8 and RST_DIR=0. A table of register
// accesses covers the register map and the set/clear feature. Hand-written
// sequences cover reset, input-path latency, edge detection, the interrupt,
// W1C against a coincident edge, and reset in the middle of an access.
// Inputs change on the falling edge and outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_gpio_bank;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en    = 1'b0;
    logic       we    = 1'b0;
    logic [2:0] addr  = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       rvalid;
    logic [7:0] pin_in = '0;
    logic [7:0] pin_out;
    logic [7:0] pin_dir;
    logic       irq;

    int checks   = 0;
    int failures = 0;

`ifdef GPIO_SETCLR_EN
    localparam logic [7:0] SET_RES = 8'hFF;
    localparam logic [7:0] CLR_RES = 8'h7E;
`else
    localparam logic [7:0] SET_RES = 8'h0F;
    localparam logic [7:0] CLR_RES = 8'h0F;
`endif

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic [7:0] exp_out;
        logic [7:0] exp_dir;
    } vec_t;

    vec_t vecs[19];

    gpio_bank #(.WIDTH(8), .RST_DIR(1'b0)) dut (
        .clock   (clock),
        .reset   (reset),
        .en      (en),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .pin_dir (pin_dir),
        .irq     (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        @(negedge clock);
        en = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clock);
        en = 1'b0; we = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [7:0] v);
        @(negedge clock);
        en = 1'b1; we = 1'b0; addr = a;
        @(negedge clock);
        en = 1'b0;
        check("read_rvalid", rvalid, 1'b1);
        v = rdata;
    endtask

    task automatic wait_negedges(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    initial begin
        logic [7:0] v;

        vecs[0]  = '{1'b1, 3'd0, 8'hA5, 8'h00,    8'hA5,   8'h00};
        vecs[1]  = '{1'b0, 3'd0, 8'h00, 8'hA5,    8'hA5,   8'h00};
        vecs[2]  = '{1'b1, 3'd1, 8'h0F, 8'hA5,    8'hA5,   8'h0F};
        vecs[3]  = '{1'b0, 3'd1, 8'h00, 8'h0F,    8'hA5,   8'h0F};
        vecs[4]  = '{1'b0, 3'd2, 8'h00, 8'h00,    8'hA5,   8'h0F};
        vecs[5]  = '{1'b1, 3'd3, 8'h55, 8'h00,    8'hA5,   8'h0F};
        vecs[6]  = '{1'b0, 3'd3, 8'h00, 8'h55,    8'hA5,   8'h0F};
        vecs[7]  = '{1'b1, 3'd5, 8'hAA, 8'h55,    8'hA5,   8'h0F};
        vecs[8]  = '{1'b0, 3'd5, 8'h00, 8'hAA,    8'hA5,   8'h0F};
        vecs[9]  = '{1'b0, 3'd4, 8'h00, 8'h00,    8'hA5,   8'h0F};
        vecs[10] = '{1'b1, 3'd0, 8'h0F, 8'h00,    8'h0F,   8'h0F};
        vecs[11] = '{1'b1, 3'd6, 8'hF0, 8'h00,    SET_RES, 8'h0F};
        vecs[12] = '{1'b0, 3'd6, 8'h00, 8'h00,    SET_RES, 8'h0F};
        vecs[13] = '{1'b0, 3'd0, 8'h00, SET_RES,  SET_RES, 8'h0F};
        vecs[14] = '{1'b1, 3'd7, 8'h81, SET_RES,  CLR_RES, 8'h0F};
        vecs[15] = '{1'b0, 3'd7, 8'h00, 8'h00,    CLR_RES, 8'h0F};
        vecs[16] = '{1'b0, 3'd0, 8'h00, CLR_RES,  CLR_RES, 8'h0F};
        vecs[17] = '{1'b1, 3'd3, 8'h00, CLR_RES,  CLR_RES, 8'h0F};
        vecs[18] = '{1'b1, 3'd5, 8'h00, CLR_RES,  CLR_RES, 8'h0F};

        // Asynchronous reset, observed before any clock edge has occurred.
        #2 reset = 1'b1;
        #1;
        check("rst_pin_out", pin_out, 8'h00);
        check("rst_pin_dir", pin_dir, 8'h00);
        check("rst_rdata",   rdata,   8'h00);
        check("rst_rvalid",  rvalid,  1'b0);
        check("rst_irq",     irq,     1'b0);
        wait_negedges(2);
        reset = 1'b0;

        // Register map walk. For write rows, the rdata column is the value
        // held over from the previous read.
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].we) begin
                write_reg(vecs[i].addr, vecs[i].wdata);
                check($sformatf("vec%0d_wr_rvalid", i), rvalid, 1'b0);
                v = rdata;
            end else begin
                read_reg(vecs[i].addr, v);
            end
            check($sformatf("vec%0d_rdata", i), v, vecs[i].exp_rdata);
            check($sformatf("vec%0d_pin_out", i), pin_out, vecs[i].exp_out);
            check($sformatf("vec%0d_pin_dir", i), pin_dir, vecs[i].exp_dir);
        end

        // A rising edge on pin 0 sets STATUS after 3 clocks and irq after 4.
        write_reg(3'd5, 8'h01);
        write_reg(3'd3, 8'h01);
        pin_in = 8'h01;
        wait_negedges(2);
        check("t3_irq_p2", irq, 1'b0);
        en = 1'b1; we = 1'b0; addr = 3'd4;
        @(negedge clock);
        check("t3_status_p3_rvalid", rvalid, 1'b1);
        check("t3_status_before", rdata, 8'h00);
        check("t3_irq_p3", irq, 1'b0);
        @(negedge clock);
        check("t3_status_after", rdata, 8'h01);
        check("t3_irq_p4", irq, 1'b1);
        en = 1'b1; we = 1'b1; addr = 3'd4; wdata = 8'h01;
        @(negedge clock);
        en = 1'b0; we = 1'b0;
        check("t3_w1c_rvalid", rvalid, 1'b0);
        check("t3_irq_w1", irq, 1'b1);
        @(negedge clock);
        check("t3_irq_w2", irq, 1'b0);

        // A falling edge on pin 3 while IRQ_EN is 0 sets STATUS and leaves irq low.
        write_reg(3'd3, 8'h00);
        write_reg(3'd5, 8'h00);
        pin_in = 8'h09;
        wait_negedges(4);
        pin_in = 8'h01;
        wait_negedges(4);
        read_reg(3'd4, v);
        check("t4_status_fall", v, 8'h08);
        check("t4_irq_masked", irq, 1'b0);
        // A W1C on bit 3 in the same cycle as a new falling edge keeps bit 3 set.
        pin_in = 8'h09;
        wait_negedges(4);
        pin_in = 8'h01;
        wait_negedges(2);
        en = 1'b1; we = 1'b1; addr = 3'd4; wdata = 8'h08;
        @(negedge clock);
        en = 1'b0; we = 1'b0;
        read_reg(3'd4, v);
        check("t4_set_wins", v, 8'h08);
        write_reg(3'd4, 8'h08);
        read_reg(3'd4, v);
        check("t4_w1c_clears", v, 8'h00);
        check("t4_irq_low", irq, 1'b0);

        // DATA_IN readback latency is 2 clocks. Writes to DATA_IN are ignored.
        pin_in = 8'h3C;
        @(negedge clock);
        en = 1'b1; we = 1'b0; addr = 3'd2;
        @(negedge clock);
        check("t5_din_old", rdata, 8'h01);
        @(negedge clock);
        en = 1'b0;
        check("t5_din_new", rdata, 8'h3C);
        write_reg(3'd2, 8'hFF);
        read_reg(3'd2, v);
        check("t5_din_ro", v, 8'h3C);
        read_reg(3'd4, v);
        check("t5_status_bit0_fall", v, 8'h01);

        // Raise irq, then assert reset asynchronously during a read strobe.
        write_reg(3'd3, 8'h01);
        @(negedge clock);
        check("t1_irq_before_rst", irq, 1'b1);
        en = 1'b1; we = 1'b0; addr = 3'd0;
        #2 reset = 1'b1;
        #1;
        check("t1_async_pin_out", pin_out, 8'h00);
        check("t1_async_pin_dir", pin_dir, 8'h00);
        check("t1_async_rdata",   rdata,   8'h00);
        check("t1_async_rvalid",  rvalid,  1'b0);
        check("t1_async_irq",     irq,     1'b0);
        @(posedge clock);
        #1;
        check("t1_aborted_rvalid", rvalid, 1'b0);
        @(negedge clock);
        reset = 1'b0; en = 1'b0;
        read_reg(3'd4, v);
        check("t1_status_after_rst", v, 8'h00);
        read_reg(3'd3, v);
        check("t1_irq_en_after_rst", v, 8'h00);
        check("t1_irq_after_rst", irq, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
